mining_work_scheduler: RTL and testbench



---
 rtl/mining_work_scheduler_pkg.sv | 20 ++
 rtl/mining_work_scheduler_if.sv | 44 ++++
 rtl/mining_work_scheduler_fifo.sv | 59 +++++
 rtl/mining_work_scheduler.sv | 130 +++++++++++++
 tb/tb_mining_work_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mining_work_scheduler_pkg.sv
// Shared types and widths for the mining work scheduler and its golden-result FIFO.
package mining_work_scheduler_pkg;

  localparam int unsigned HASH_W  = 256;
  localparam int unsigned Y_W     = 96;
  localparam int unsigned NONCE_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StRun,
    StExhausted
  } sched_state_e;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } result_t;

endpackage

// File: rtl/mining_work_scheduler_if.sv
// Work-in, hasher and result-out signal bundle of the mining work scheduler.
interface mining_work_scheduler_if;
  import mining_work_scheduler_pkg::*;

  logic               work_valid;
  logic               work_ready;
  logic [HASH_W-1:0]  work_x;
  logic [Y_W-1:0]     work_y;
  logic [NONCE_W-1:0] work_nonce_start;
  logic [NONCE_W-1:0] work_nonce_end;

  logic [HASH_W-1:0]  hs_x;
  logic [Y_W-1:0]     hs_y;
  logic [NONCE_W-1:0] hs_nonce;
  logic               hs_accepted;
  logic [HASH_W-1:0]  hs_hash;
  logic [NONCE_W-1:0] hs_out_nonce;

  logic               res_valid;
  logic               res_ready;
  logic [HASH_W-1:0]  res_hash;
  logic [NONCE_W-1:0] res_nonce;

  logic               busy;
  logic               exhausted;
  logic [7:0]         drop_count;

  // Scheduler side
  modport slave (
    input  work_valid, work_x, work_y, work_nonce_start, work_nonce_end,
    input  hs_accepted, hs_hash, hs_out_nonce, res_ready,
    output work_ready, hs_x, hs_y, hs_nonce, res_valid, res_hash, res_nonce,
    output busy, exhausted, drop_count
  );

  // Environment side (UART paths and hasher)
  modport master (
    output work_valid, work_x, work_y, work_nonce_start, work_nonce_end,
    output hs_accepted, hs_hash, hs_out_nonce, res_ready,
    input  work_ready, hs_x, hs_y, hs_nonce, res_valid, res_hash, res_nonce,
    input  busy, exhausted, drop_count
  );

endinterface

// File: rtl/mining_work_scheduler_fifo.sv
// Show-ahead FIFO of golden results; push and pop in one cycle both take effect.
module golden_result_fifo
  import mining_work_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  result_t data_i,
  input  logic    pop_i,
  output result_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  result_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so full only blocks an unpaired push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mining_work_scheduler.sv
// Feeds work units into the double-SHA hasher, walks the nonce range and queues
// golden hashes (with stale-result drain and repeat suppression) for transmission.
module mining_work_scheduler
  import mining_work_scheduler_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 80,
  parameter int unsigned TARGET_ZEROS = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  mining_work_scheduler_if.slave bus
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  sched_state_e       state_q, state_d;
  logic [CntW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [HASH_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] end_q, end_d;
  logic [NONCE_W-1:0] dedup_q, dedup_d;
  logic               dedup_vld_q, dedup_vld_d;
  logic [7:0]         drop_q, drop_d;

  logic    work_ready, accept, checking, golden, push, pop;
  logic    fifo_full, fifo_empty;
  result_t push_data, head;

  assign work_ready = (state_q != StDrain);
  assign accept     = bus.work_valid && work_ready;
  assign checking   = (state_q == StRun) || (state_q == StExhausted);
  assign golden     = (bus.hs_hash[HASH_W-1 -: TARGET_ZEROS] == '0);
  // The held end nonce keeps re-emerging from the pipeline; only a new nonce is pushed.
  assign push       = checking && golden && (!dedup_vld_q || (bus.hs_out_nonce != dedup_q));
  assign pop        = !fifo_empty && bus.res_ready;
  assign push_data  = '{nonce: bus.hs_out_nonce, hash: bus.hs_hash};

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    nonce_d     = nonce_q;
    end_d       = end_q;
    dedup_d     = dedup_q;
    dedup_vld_d = dedup_vld_q;
    drop_d      = drop_q;

    unique case (state_q)
      StDrain: begin
        if (drain_cnt_q == '0) state_d = StRun;
        else drain_cnt_d = drain_cnt_q - 1'b1;
      end
      StRun: begin
        if (bus.hs_accepted) begin
          if (nonce_q == end_q) state_d = StExhausted;
          else nonce_d = nonce_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (push) begin
      dedup_d     = bus.hs_out_nonce;
      dedup_vld_d = 1'b1;
      if (fifo_full && !pop && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
    end

    if (accept) begin
      state_d     = StDrain;
      drain_cnt_d = CntW'(DRAIN_CYCLES - 1);
      x_d         = bus.work_x;
      y_d         = bus.work_y;
      nonce_d     = bus.work_nonce_start;
      end_d       = bus.work_nonce_end;
      dedup_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      dedup_q     <= '0;
      dedup_vld_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      nonce_q     <= nonce_d;
      end_q       <= end_d;
      dedup_q     <= dedup_d;
      dedup_vld_q <= dedup_vld_d;
      drop_q      <= drop_d;
    end
  end

  golden_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign bus.work_ready = work_ready;
  assign bus.hs_x       = x_q;
  assign bus.hs_y       = y_q;
  assign bus.hs_nonce   = nonce_q;
  assign bus.res_valid  = !fifo_empty;
  assign bus.res_hash   = head.hash;
  assign bus.res_nonce  = head.nonce;
  assign bus.busy       = (state_q == StDrain) || (state_q == StRun);
  assign bus.exhausted  = (state_q == StExhausted);
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_mining_work_scheduler.sv
// Randomized bench for mining_work_scheduler against a transaction-level reference model.
module tb_mining_work_scheduler;
  import mining_work_scheduler_pkg::*;

  localparam int unsigned DrainCycles = 80;
  localparam int unsigned FifoDepth   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  mining_work_scheduler_if bus ();

  mining_work_scheduler #(
    .DRAIN_CYCLES(DrainCycles),
    .TARGET_ZEROS(32),
    .FIFO_DEPTH  (FifoDepth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a work unit is a range of m_len nonces preceded by a drain period.
  bit           m_active;
  int           m_drain_left;
  logic [31:0]  m_start, m_end;
  longint       m_len, m_issued;
  logic [255:0] m_x;
  logic [95:0]  m_y;
  bit           m_dedup_vld;
  logic [31:0]  m_dedup;
  result_t      m_q[$];
  int           m_drop;

  function automatic void model_reset();
    m_active = 0; m_drain_left = 0; m_start = '0; m_end = '0; m_len = 0; m_issued = 0;
    m_x = '0; m_y = '0; m_dedup_vld = 0; m_dedup = '0; m_q.delete(); m_drop = 0;
  endfunction

  function automatic bit m_done();
    return m_active && m_drain_left == 0 && m_issued == m_len;
  endfunction

  task automatic check_outputs();
    logic [31:0] exp_nonce;
    exp_nonce = !m_active ? 32'h0 : m_start + 32'(m_done() ? m_len - 1 : m_issued);
    check_eq("work_ready", 288'(bus.work_ready), 288'(m_drain_left == 0));
    check_eq("busy", 288'(bus.busy), 288'(m_active && !m_done()));
    check_eq("exhausted", 288'(bus.exhausted), 288'(m_done()));
    check_eq("hs_nonce", 288'(bus.hs_nonce), 288'(exp_nonce));
    check_eq("hs_x", 288'(bus.hs_x), 288'(m_x));
    check_eq("hs_y", 288'(bus.hs_y), 288'(m_y));
    check_eq("res_valid", 288'(bus.res_valid), 288'(m_q.size() != 0));
    check_eq("res_nonce", 288'(bus.res_nonce), 288'(m_q.size() != 0 ? m_q[0].nonce : 32'h0));
    check_eq("res_hash", 288'(bus.res_hash), 288'(m_q.size() != 0 ? m_q[0].hash : 256'h0));
    check_eq("drop_count", 288'(bus.drop_count), 288'(m_drop));
  endtask

  // Check current outputs, advance the model with the inputs the DUT sees, then clock.
  task automatic cycle();
    bit run_phase, accept, gold, push, pop;
    int sz;
    logic [31:0] diff;
    check_outputs();
    run_phase = m_active && m_drain_left == 0;
    accept    = bus.work_valid && (m_drain_left == 0);
    gold      = (bus.hs_hash[255:224] == 32'h0);
    push      = run_phase && gold && !(m_dedup_vld && bus.hs_out_nonce == m_dedup);
    sz        = m_q.size();
    pop       = bus.res_ready && sz > 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_dedup = bus.hs_out_nonce;
      m_dedup_vld = 1;
      if (sz < int'(FifoDepth) || pop) m_q.push_back('{nonce: bus.hs_out_nonce, hash: bus.hs_hash});
      else if (m_drop < 255) m_drop++;
    end
    if (accept) begin
      diff = bus.work_nonce_end - bus.work_nonce_start;
      m_active = 1; m_drain_left = DrainCycles; m_issued = 0; m_dedup_vld = 0;
      m_start = bus.work_nonce_start; m_end = bus.work_nonce_end; m_len = longint'(diff) + 1;
      m_x = bus.work_x; m_y = bus.work_y;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end else if (m_active && m_issued < m_len && bus.hs_accepted) begin
      m_issued++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hash(input bit gold, input logic [31:0] n);
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    if (gold) h[255:224] = 32'h0;
    else if ($urandom_range(1) == 0) h[255:224] = 32'h0000_0001;
    else h[255:224] = h[255:224] | 32'h8000_0000;
    bus.hs_hash = h;
    bus.hs_out_nonce = n;
  endtask

  task automatic rand_side();
    drive_hash($urandom_range(2) == 0, 32'h40 + 32'($urandom_range(3)));
    bus.res_ready = 1'($urandom_range(1));
  endtask

  task automatic offer_work(input logic [31:0] s, input logic [31:0] e);
    bus.work_x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.work_y = {$urandom, $urandom, $urandom};
    bus.work_nonce_start = s;
    bus.work_nonce_end = e;
    bus.work_valid = 1'b1;
    cycle();
    bus.work_valid = 1'b0;
  endtask

  task automatic run_until_exhausted(input int max_cycles, input bit rand_mode);
    int i = 0;
    while (!m_done() && i < max_cycles) begin
      bus.hs_accepted = rand_mode ? 1'($urandom_range(1)) : 1'b1;
      if (rand_mode) rand_side();
      cycle();
      i++;
    end
    check_eq("exhaust_reached", 288'(bus.exhausted), 288'(1));
    check_eq("held_end_nonce", 288'(bus.hs_nonce), 288'(m_end));
  endtask

  task automatic nongolden_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_hash(1'b0, 32'h0);
      cycle();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    logic [31:0] exp_order[4];
    int d0;
    bus.work_valid = 1'b0; bus.work_x = '0; bus.work_y = '0;
    bus.work_nonce_start = '0; bus.work_nonce_end = '0;
    bus.hs_accepted = 1'b0; bus.hs_hash = '1; bus.hs_out_nonce = '0; bus.res_ready = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;

    // Basic range with the hasher always accepting, then hold in EXHAUSTED
    offer_work(32'h10, 32'h12);
    run_until_exhausted(200, 1'b0);
    repeat (3) cycle();

    // Range wrapping through 0xFFFFFFFF
    offer_work(32'hFFFF_FFFE, 32'h0000_0001);
    run_until_exhausted(200, 1'b0);

    // Random short ranges, random hasher back-pressure and result traffic
    for (int r = 0; r < 6; r++) begin
      s = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(5)) : $urandom;
      offer_work(s, s + 32'($urandom_range(7)));
      run_until_exhausted(400, 1'b1);
    end
    bus.res_ready = 1'b1;
    nongolden_cycles(6);

    // Golden hashes during drain are stale
    bus.res_ready = 1'b0;
    bus.hs_accepted = 1'b0;
    offer_work(32'h0, 32'hFFFF);
    for (int i = 0; i < int'(DrainCycles); i++) begin
      drive_hash(1'b1, 32'h1234);
      cycle();
    end
    drive_hash(1'b0, 32'h0);
    check_eq("stale_discard", 288'(bus.res_valid), 288'(0));

    // Same golden nonce three times queues one entry
    for (int i = 0; i < 3; i++) begin
      drive_hash(1'b1, 32'hb295_7c02);
      cycle();
    end
    nongolden_cycles(1);
    check_eq("dedup_head", 288'(bus.res_nonce), 288'(32'hb295_7c02));
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    check_eq("dedup_single", 288'(bus.res_valid), 288'(0));

    // Top word 0x00000001 is one bit short of golden
    bus.hs_hash = {32'h0000_0001, 224'h0};
    bus.hs_out_nonce = 32'h77;
    cycle();
    nongolden_cycles(1);
    check_eq("near_golden", 288'(bus.res_valid), 288'(0));

    // Overflow: six distinct pushes into a four-deep FIFO
    d0 = m_drop;
    for (int i = 0; i < 6; i++) begin
      drive_hash(1'b1, 32'h100 + 32'(i));
      cycle();
    end
    nongolden_cycles(1);
    check_eq("overflow_drops", 288'(bus.drop_count), 288'(d0 + 2));
    bus.res_ready = 1'b1;
    drive_hash(1'b1, 32'h200);
    cycle();
    drive_hash(1'b0, 32'h0);
    check_eq("full_push_pop", 288'(bus.drop_count), 288'(d0 + 2));
    exp_order = '{32'h101, 32'h102, 32'h103, 32'h200};
    for (int k = 0; k < 4; k++) begin
      check_eq("pop_order", 288'(bus.res_nonce), 288'(exp_order[k]));
      cycle();
    end
    check_eq("drained", 288'(bus.res_valid), 288'(0));

    // Preempt mid-RUN; queued results survive the switch
    bus.res_ready = 1'b0;
    bus.hs_accepted = 1'b1;
    nongolden_cycles(3);
    drive_hash(1'b1, 32'h301); cycle();
    drive_hash(1'b1, 32'h302); cycle();
    drive_hash(1'b0, 32'h0);
    offer_work(32'h5000, 32'h5003);
    check_eq("preempt_nonce", 288'(bus.hs_nonce), 288'(32'h5000));
    check_eq("preempt_keep", 288'(bus.res_nonce), 288'(32'h301));
    for (int i = 0; i < 10; i++) begin
      drive_hash(1'b1, 32'h400 + 32'(i));
      cycle();
    end
    drive_hash(1'b0, 32'h0);
    run_until_exhausted(200, 1'b0);

    // Random soak including occasional new work
    for (int i = 0; i < 400; i++) begin
      bus.hs_accepted = 1'($urandom_range(1));
      rand_side();
      if ($urandom_range(39) == 0) begin
        s = $urandom;
        bus.work_x = {8{$urandom}};
        bus.work_y = {3{$urandom}};
        bus.work_nonce_start = s;
        bus.work_nonce_end = s + 32'($urandom_range(5));
        bus.work_valid = 1'b1;
      end
      cycle();
      bus.work_valid = 1'b0;
    end

    // Asynchronous reset mid-RUN clears everything without a clock edge
    bus.res_ready = 1'b0;
    bus.hs_accepted = 1'b1;
    offer_work(32'h7000, 32'h7FFF);
    nongolden_cycles(int'(DrainCycles) + 5);
    drive_hash(1'b1, 32'h7777);
    cycle();
    drive_hash(1'b0, 32'h0);
    #10;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
